// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter slice: default width, IDLE/RUN
// state encoding (also used by the up-counter bench) and the all-zero count.
package down_counter_pkg;

  localparam int CNT_W = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } cnt_state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

endpackage

// File: rtl/down_counter_if.sv
// Control/status bundle of the down_counter: load/enable/value in, count and
// zero/terminal-count flags out.
interface down_counter_if
  import down_counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
);

  logic             load;
  logic [WIDTH-1:0] D;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             zero;
  logic             tc;

  modport master (
    output load, D, en,
    input  Q, zero, tc
  );

  modport slave (
    input  load, D, en,
    output Q, zero, tc
  );

endinterface

// File: rtl/down_counter_dec_cell.sv
// dec_cell: one-bit half-subtractor, chained to form the borrow-ripple
// decrementer of the down_counter.
module dec_cell (
  input  logic q,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = q ^ bin;
  assign bout = ~q & bin;

endmodule

// File: rtl/down_counter.sv
// down_counter: loadable down-counter with registered terminal-count pulse.
// Optional periodic reload is enabled by defining DOWN_COUNTER_RELOAD_EN.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  down_counter_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH:0]   borrow_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;
  logic             zero_s;
  logic             at_one_s;
  cnt_state_e       state_s;
`ifdef DOWN_COUNTER_RELOAD_EN
  logic [WIDTH-1:0] reload_r;
`endif

  assign borrow_s[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_dec
      dec_cell u_cell (
        .q    (q_r[i]),
        .bin  (borrow_s[i]),
        .d    (dec_s[i]),
        .bout (borrow_s[i+1])
      );
    end
  endgenerate

  // Decrementing zero is the only case that borrows out of the MSB.
  assign zero_s   = borrow_s[WIDTH];
  assign at_one_s = (q_r == {{(WIDTH-1){1'b0}}, 1'b1});

  // State is a pure function of the count.
  always_comb begin
    if (zero_s) begin
      state_s = ST_IDLE;
    end else begin
      state_s = ST_RUN;
    end
  end

  // Load has priority over enable; the last step from 1 to 0 raises tc.
  always_comb begin
    q_nxt_s  = q_r;
    tc_nxt_s = 1'b0;
    if (bus.load) begin
      q_nxt_s = bus.D;
    end else if (bus.en) begin
      if (state_s == ST_RUN) begin
        q_nxt_s  = dec_s;
        tc_nxt_s = at_one_s;
      end else begin
`ifdef DOWN_COUNTER_RELOAD_EN
        q_nxt_s = reload_r;
`else
        q_nxt_s = q_r;
`endif
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // Count and terminal-count flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r  <= WIDTH'(CNT_ZERO);
      tc_r <= 1'b0;
    end else begin
      q_r  <= q_nxt_s;
      tc_r <= tc_nxt_s;
    end
  end

`ifdef DOWN_COUNTER_RELOAD_EN
  // Reload value tracks every loaded start value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_r <= WIDTH'(CNT_ZERO);
    end else if (bus.load) begin
      reload_r <= bus.D;
    end else begin
      reload_r <= reload_r;
    end
  end
`endif

  assign bus.Q    = q_r;
  assign bus.zero = zero_s;
  assign bus.tc   = tc_r;

endmodule

// File: tb/tb_down_counter.sv
// Directed self-checking bench for down_counter (one-shot build by default,
// periodic-reload steps when DOWN_COUNTER_RELOAD_EN is defined).
module tb_down_counter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  down_counter_if #(.WIDTH(6)) bus ();

  down_counter #(.WIDTH(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] q, input logic tc, input logic z);
    chk({tag, ".Q"}, 32'(bus.Q), 32'(q));
    chk({tag, ".tc"}, 32'(bus.tc), 32'(tc));
    chk({tag, ".zero"}, 32'(bus.zero), 32'(z));
  endtask

  initial begin
    logic [5:0] en_seq [6];
    logic [5:0] q_seq  [6];
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    bus.load = 1'b0;
    bus.en   = 1'b0;
    bus.D    = 6'd0;
    #1 rst = 1'b1;
    #1;
    chk_all("reset", 6'd0, 1'b0, 1'b1);
    step();
    step();
    rst = 1'b0;

    // Reset mid-count
    bus.load = 1'b1; bus.D = 6'd20;
    step();
    chk_all("load20", 6'd20, 1'b0, 1'b0);
    bus.load = 1'b0; bus.en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("count20.Q", 32'(bus.Q), 32'(20 - k));
    end
    #3 rst = 1'b1;
    #1;
    chk_all("async_rst", 6'd0, 1'b0, 1'b1);
    bus.en = 1'b0;
    step();
    rst = 1'b0;

    // One-shot countdown from 3, load and en together on the load edge
    bus.load = 1'b1; bus.D = 6'd3; bus.en = 1'b1;
    step();
    chk_all("os3_load", 6'd3, 1'b0, 1'b0);
    bus.load = 1'b0;
    step(); chk_all("os3_2", 6'd2, 1'b0, 1'b0);
    step(); chk_all("os3_1", 6'd1, 1'b0, 1'b0);
    step(); chk_all("os3_0", 6'd0, 1'b1, 1'b1);
`ifndef DOWN_COUNTER_RELOAD_EN
    step(); chk_all("os3_hold0a", 6'd0, 1'b0, 1'b1);
    step(); chk_all("os3_hold0b", 6'd0, 1'b0, 1'b1);
`endif

    // Enable gaps
    bus.load = 1'b1; bus.D = 6'd4; bus.en = 1'b0;
    step();
    chk_all("gap_load", 6'd4, 1'b0, 1'b0);
    bus.load = 1'b0;
    en_seq = '{6'd1, 6'd0, 6'd1, 6'd0, 6'd1, 6'd1};
    q_seq  = '{6'd3, 6'd3, 6'd2, 6'd2, 6'd1, 6'd0};
    for (int k = 0; k < 6; k++) begin
      bus.en = en_seq[k][0];
      step();
      chk("gap.Q", 32'(bus.Q), 32'(q_seq[k]));
      chk("gap.tc", 32'(bus.tc), (k == 5) ? 32'd1 : 32'd0);
    end

    // Priority: load beats en at Q == 1
    bus.en = 1'b0; bus.load = 1'b1; bus.D = 6'd1;
    step();
    chk_all("pri_q1", 6'd1, 1'b0, 1'b0);
    bus.D = 6'd63; bus.en = 1'b1;
    step();
    chk_all("pri_load63", 6'd63, 1'b0, 1'b0);
    bus.D = 6'd1;
    step();
    bus.D = 6'd0;
    step();
    chk_all("pri_load0", 6'd0, 1'b0, 1'b1);
    bus.load = 1'b0; bus.en = 1'b0;

`ifdef DOWN_COUNTER_RELOAD_EN
    // Periodic reload
    bus.load = 1'b1; bus.D = 6'd2; bus.en = 1'b1;
    step();
    chk_all("rl_load2", 6'd2, 1'b0, 1'b0);
    bus.load = 1'b0;
    step(); chk_all("rl_1a", 6'd1, 1'b0, 1'b0);
    step(); chk_all("rl_0a", 6'd0, 1'b1, 1'b1);
    step(); chk_all("rl_2", 6'd2, 1'b0, 1'b0);
    step(); chk_all("rl_1b", 6'd1, 1'b0, 1'b0);
    step(); chk_all("rl_0b", 6'd0, 1'b1, 1'b1);
    bus.load = 1'b1; bus.D = 6'd0;
    step();
    bus.load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all("rl_zero", 6'd0, 1'b0, 1'b1);
    end
    bus.en = 1'b0;
`endif

    // Full-scale countdown
    bus.load = 1'b1; bus.D = 6'd63; bus.en = 1'b1;
    step();
    bus.load = 1'b0;
    for (int k = 1; k <= 63; k++) begin
      step();
      chk("fs.Q", 32'(bus.Q), 32'(63 - k));
      chk("fs.tc", 32'(bus.tc), (k == 63) ? 32'd1 : 32'd0);
    end
    chk("fs.zero", 32'(bus.zero), 32'd1);
`ifndef DOWN_COUNTER_RELOAD_EN
    step();
    chk_all("fs_nowrap", 6'd0, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter.md
# down_counter

Loadable down-counter with terminal-count pulse; the decrementing counterpart of the team's free-running 6-bit up-counter. Software or a controller FSM loads a start value, and the block counts toward zero on each enabled clock. It flags arrival at zero with a one-cycle pulse, for interval timing and delay generation. It is built in the same structural style from per-bit cells plus state flops.

## Interface
- WIDTH, 6, counter width in bits (min 2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- load  input  1  load D into counter on next edge; priority over en
- D  input  WIDTH  load value
- en  input  1  count enable; decrement by 1 per enabled edge
- Q  output  WIDTH  current count, registered
- zero  output  1  combinational decode of Q == 0
- tc  output  1  terminal-count pulse, registered, one cycle

## Operation
- States: IDLE (Q == 0, no pulse pending) and RUN (Q != 0). The state is derived from Q plus one tc flop; no separate encoding beyond that.
- Reset (asserted at any time, including mid-count): Q = 0, tc = 0, state IDLE, reload register = 0. Takes effect immediately, independent of clk.
- Per-edge priority: load, then en, then hold.
- load = 1:
  - Q <= D, tc <= 0, regardless of en.
  - D == 0 leaves or puts the block in IDLE with no tc.
- load = 0, en = 1, Q > 1: Q <= Q - 1, tc <= 0.
- load = 0, en = 1, Q == 1: Q <= 0, tc <= 1 (RUN -> IDLE).
- load = 0, en = 1, Q == 0: behaviour depends on configuration (below). Q never wraps to all-ones.
- en = 0 and load = 0: Q holds, tc <= 0.
- Arithmetic: unsigned, WIDTH bits, borrow-chain decrement; the final borrow-out is discarded.

## Timing
- Load latency is 1 cycle: Q = D after the edge on which load was sampled high.
- A count loaded with N and held with en = 1 continuously reaches Q = 0 exactly N edges after the load edge.
- tc is high during the same cycle in which Q first reads 0, and only for that cycle.
- zero has no latency relative to Q. It is purely combinational and is high whenever Q == 0, including after reset and after a load of 0.
- load and en asserted together: load wins and no decrement occurs that cycle.
- Back-to-back load while Q == 1 and en = 1: load wins and tc is not asserted.

## Configuration
- Macro: DOWN_COUNTER_RELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures D on every load edge.
  - At Q == 0 with en = 1 and load = 0, Q <= reload register, returning to RUN. This gives a periodic tc every R+1 enabled cycles for reload value R.
  - If the reload register is 0, Q stays 0 and tc stays 0.
- Undefined: no reload register. At Q == 0 with en = 1, Q holds at 0, the block stays IDLE and tc stays 0 (one-shot).

## Structure
- Shared package holds:
  - CNT_W = 6, the default WIDTH.
  - The IDLE/RUN state enumeration, which is shared with the up-counter bench.
  - A helper constant for the all-zero count.
- One sub-module: dec_cell, a 1-bit half-subtractor (inputs q and bin; outputs d and bout).
  - It is instantiated WIDTH times as a ripple borrow chain.
  - The LSB has bin tied to 1.
- Output and state flops use the existing dff cell with an asynchronous clear added, or an equivalent behavioural always block.
- Load/enable muxing sits in the top level.

## Test plan
- Reset mid-count: load 20, count 5 cycles, assert rst asynchronously between edges -> Q = 0, tc = 0, zero = 1 immediately.
- One-shot countdown: load 3, en held high -> Q sequence 3,2,1,0,0,0. tc = 1 only in the first Q = 0 cycle. zero = 1 from that cycle onward.
- Enable gaps: load 4, toggle en 1,0,1,0,1,1 -> Q = 3,3,2,2,1,0, with tc on the final cycle only.
- Priority: at Q = 1 assert load = 1, D = 63, en = 1 together -> Q = 63, tc = 0. With D = 0 instead -> Q = 0, tc = 0, zero = 1.
- With DOWN_COUNTER_RELOAD_EN: load 2, en held high -> Q = 2,1,0,2,1,0, with tc every third cycle. Reload register 0 -> Q remains 0 and tc never asserts.
- Full-scale: load 63, en held high -> tc asserts exactly 63 edges after the load edge, with no wrap to 63 afterward in one-shot mode.
